// File: rtl/sistema_epy_mem_reader_pkg.sv
// sistema_epy_mm_pkg: shared FSM type and bus constants for the Sistema_Epy memory reader
package sistema_epy_mm_pkg;
   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;
   localparam logic [3:0] BE_ALL = 4'hF;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/sistema_epy_mem_reader_if.sv
// sistema_epy_mem_reader_if: Avalon-MM read bus plus Avalon-ST source of the memory reader
interface sistema_epy_mem_reader_if import sistema_epy_mm_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic [ADDR_W-1:0] avm_address;
   logic avm_read;
   logic [3:0] avm_byteenable;
   logic avm_waitrequest;
   logic avm_readdatavalid;
   logic [DATA_W-1:0] avm_readdata;
   logic [DATA_W-1:0] src_data;
   logic src_valid;
   logic src_ready;
   modport master (
      output avm_address, avm_read, avm_byteenable, src_data, src_valid,
      input avm_waitrequest, avm_readdatavalid, avm_readdata, src_ready
   );
   modport slave (
      input avm_address, avm_read, avm_byteenable, src_data, src_valid,
      output avm_waitrequest, avm_readdatavalid, avm_readdata, src_ready
   );
endinterface

// File: rtl/sistema_epy_mem_reader_fifo.sv
// sistema_epy_sync_fifo: flop-based synchronous FIFO, head word always visible on dout
module sistema_epy_sync_fifo #(
   parameter int W = 32,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push,
   input  logic pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [CW-1:0] count,
   output logic empty,
   output logic full
);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         mem <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) mem[wr_ptr] <= din;
         wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
         count <= count + CW'(push) - CW'(pop);
      end
   assign dout = mem[rd_ptr];
   assign empty = count == '0;
   assign full = count == CW'(DEPTH);
endmodule

// File: rtl/sistema_epy_mem_reader.sv
// sistema_epy_mem_reader: Avalon-MM block read master streaming words out in address order
module sistema_epy_mem_reader import sistema_epy_mm_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0] length,
   output logic busy,
   output logic done,
   sistema_epy_mem_reader_if.master bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t state;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0] remaining;
   logic [CW-1:0] outstanding, fifo_count;
   logic fifo_empty, fifo_full, accept, rsp, push, pop;
   // reads in flight plus buffered words never exceed the FIFO, so responses always fit
   assign bus.avm_read = state == ISSUE && ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
   assign bus.avm_address = addr;
   assign bus.avm_byteenable = BE_ALL;
   assign bus.src_valid = !fifo_empty;
   assign busy = state == ISSUE || state == DRAIN;
   assign done = state == DONE;
   assign accept = bus.avm_read && !bus.avm_waitrequest;
   assign rsp = bus.avm_readdatavalid && busy;
   assign push = rsp && !fifo_full;
   assign pop = bus.src_valid && bus.src_ready;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         addr <= '0;
         remaining <= '0;
         outstanding <= '0;
      end else begin
         outstanding <= outstanding + CW'(accept) - CW'(rsp);
         case (state)
            IDLE: if (start) begin
               addr <= base_addr;
               remaining <= length;
               outstanding <= '0;
               state <= length == '0 ? DONE : ISSUE;
            end
            ISSUE: if (accept) begin
               addr <= addr + ADDR_W'(1);
               remaining <= remaining - LEN_W'(1);
               if (remaining == LEN_W'(1)) state <= DRAIN;
            end
            // finish as soon as the FIFO empties this cycle so done follows the last pop
            DRAIN: if (outstanding == '0 && fifo_count == CW'(pop)) state <= DONE;
            default: state <= IDLE;
         endcase
      end
   sistema_epy_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset_n(reset_n),
      .push(push),
      .pop(pop),
      .din(bus.avm_readdata),
      .dout(bus.src_data),
      .count(fifo_count),
      .empty(fifo_empty),
      .full(fifo_full)
   );
endmodule

// File: tb/tb_sistema_epy_mem_reader.sv
// tb_sistema_epy_mem_reader: directed checks of the reader against a zero-wait, one-cycle-latency slave
module tb_sistema_epy_mem_reader;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [15:0] length = '0;
   logic busy, done;
   logic rdv_q = 1'b0;
   logic inj_rdv = 1'b0;
   logic [31:0] rdata_q = '0;
   logic [31:0] inj_data = '0;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_pop = 0;
   int valid_seen = 0;
   logic [15:0] acc_q[$];
   logic [31:0] dat_q[$];

   sistema_epy_mem_reader_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   sistema_epy_mem_reader #(.ADDR_W(16), .DATA_W(32), .LEN_W(16), .FIFO_DEPTH(4)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .base_addr(base_addr),
      .length(length),
      .busy(busy),
      .done(done),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [15:0] a);
      return {~a, a};
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      rdv_q <= bus.avm_read && !bus.avm_waitrequest;
      rdata_q <= word(bus.avm_address);
   end
   assign bus.avm_readdatavalid = rdv_q | inj_rdv;
   assign bus.avm_readdata = inj_rdv ? inj_data : rdata_q;

   always @(negedge clk) begin
      if (bus.avm_read && !bus.avm_waitrequest) acc_q.push_back(bus.avm_address);
      if (bus.src_valid && bus.src_ready) begin
         dat_q.push_back(bus.src_data);
         last_pop = cyc;
      end
      if (bus.src_valid) valid_seen++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear();
      acc_q.delete();
      dat_q.delete();
      done_cnt = 0;
      valid_seen = 0;
   endtask

   task automatic start_xfer(input logic [15:0] b, input logic [15:0] n);
      base_addr = b;
      length = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, 32'(done), 32'(1));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'(0));
      tick();
      tick();
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
   endtask

   task automatic chk_stream(input string tag, input logic [15:0] b, input int n);
      chk({tag, "_acc_n"}, 32'(acc_q.size()), 32'(n));
      chk({tag, "_dat_n"}, 32'(dat_q.size()), 32'(n));
      for (int i = 0; i < acc_q.size(); i++) chk({tag, "_addr"}, 32'(acc_q[i]), 32'(16'(b + 16'(i))));
      for (int i = 0; i < dat_q.size(); i++) chk({tag, "_data"}, dat_q[i], word(16'(b + 16'(i))));
   endtask

   initial begin
      bus.avm_waitrequest = 1'b0;
      bus.src_ready = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_read", 32'(bus.avm_read), 32'(0));
      chk("rst_addr", 32'(bus.avm_address), 32'(0));
      chk("rst_valid", 32'(bus.src_valid), 32'(0));
      chk("rst_data", bus.src_data, 32'h0);
      chk("byteenable", 32'(bus.avm_byteenable), 32'hF);
      reset_n = 1'b1;
      tick();

      clear();
      start_xfer(16'h0010, 16'd8);
      chk("t1_c1_busy", 32'(busy), 32'(1));
      chk("t1_c1_read", 32'(bus.avm_read), 32'(1));
      chk("t1_c1_addr", 32'(bus.avm_address), 32'h10);
      tick();
      chk("t1_c2_valid", 32'(bus.src_valid), 32'(0));
      tick();
      chk("t1_c3_valid", 32'(bus.src_valid), 32'(1));
      chk("t1_c3_data", bus.src_data, 32'hFFEF_0010);
      wait_done("t1");
      chk("t1_done_after_pop", 32'(done_cyc), 32'(last_pop + 1));
      chk_stream("t1", 16'h0010, 8);

      clear();
      start_xfer(16'h0099, 16'd0);
      chk("t2_done", 32'(done), 32'(1));
      chk("t2_busy", 32'(busy), 32'(0));
      chk("t2_read", 32'(bus.avm_read), 32'(0));
      tick();
      chk("t2_done_low", 32'(done), 32'(0));
      tick();
      chk("t2_acc_n", 32'(acc_q.size()), 32'(0));
      chk("t2_valid_seen", 32'(valid_seen), 32'(0));

      clear();
      start_xfer(16'h0020, 16'd4);
      tick();
      bus.avm_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("t3_stall_addr", 32'(bus.avm_address), 32'h21);
         chk("t3_stall_read", 32'(bus.avm_read), 32'(1));
         tick();
      end
      bus.avm_waitrequest = 1'b0;
      wait_done("t3");
      chk_stream("t3", 16'h0020, 4);

      clear();
      bus.src_ready = 1'b0;
      start_xfer(16'h0030, 16'd10);
      repeat (12) tick();
      chk("t4_acc_held", 32'(acc_q.size()), 32'(4));
      chk("t4_read_low", 32'(bus.avm_read), 32'(0));
      chk("t4_busy", 32'(busy), 32'(1));
      chk("t4_valid", 32'(bus.src_valid), 32'(1));
      chk("t4_head", bus.src_data, 32'hFFCF_0030);
      bus.src_ready = 1'b1;
      wait_done("t4");
      chk_stream("t4", 16'h0030, 10);

      clear();
      start_xfer(16'hFFFE, 16'd4);
      wait_done("t5");
      chk_stream("t5", 16'hFFFE, 4);
      chk("t5_wrap_addr", 32'(acc_q[2]), 32'h0000);
      chk("t5_wrap_data", dat_q[3], 32'hFFFE_0001);

      clear();
      start_xfer(16'h0040, 16'd6);
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'(0));
      chk("t6_rst_read", 32'(bus.avm_read), 32'(0));
      chk("t6_rst_addr", 32'(bus.avm_address), 32'(0));
      chk("t6_rst_valid", 32'(bus.src_valid), 32'(0));
      chk("t6_rst_data", bus.src_data, 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      inj_data = 32'hDEAD_BEEF;
      inj_rdv = 1'b1;
      tick();
      inj_rdv = 1'b0;
      chk("t6_stale_valid", 32'(bus.src_valid), 32'(0));
      tick();
      chk("t6_idle_busy", 32'(busy), 32'(0));
      clear();
      start_xfer(16'h0050, 16'd3);
      wait_done("t6");
      chk_stream("t6", 16'h0050, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
